sticky_rr_arbiter: RTL
======================

# sticky_rr_arbiter

Parametrised NR-way round-robin arbiter with sticky grants. A line keeps its grant while it keeps requesting, up to a programmable burst limit, then yields to the next pending line in rotation. Adds a real stall, a hold limit and arbitrary requester count over the fixed 4-way sticky arbiter. It sits in front of shared resources such as event-queue ports and memory request channels, where back-to-back ownership by one core improves locality but starvation is not acceptable.

## Interface
- NR, 4: number of requesters; any value ≥ 2.
- MAX_HOLD, 4: maximum consecutive grants to one line while others wait; 0 = unlimited (pure sticky).
- EW, clog2(NR): width of encoded grant (derived, not overridden).
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NR  request vector, one bit per line.
- stall  in  1  downstream not ready; suppresses granting and freezes state.
- vgnt  out  NR  one-hot grant vector (all-zero when eval=0).
- egnt  out  EW  encoded grant index (0 when eval=0).
- eval  out  1  a grant is issued this cycle.

## Operation
- State registers: last_gnt (EW bits), last_vld (1), hold_cnt (clog2(MAX_HOLD+1) bits, saturating), ptr (EW bits, round-robin start).
- Reset (async): last_gnt=0, last_vld=0, hold_cnt=0, ptr=0. While reset is high, eval=0, vgnt=0, egnt=0.
- Grant is combinational from req and state (zero-latency, same cycle as req).
- eval = !stall && |req.
- Sticky case: if last_vld && req[last_gnt] && (MAX_HOLD==0 || hold_cnt < MAX_HOLD || no other line requests), grant last_gnt.
- Rotation case: otherwise grant the first requesting line scanning ptr, ptr+1, … wrapping mod NR. When rotation is forced by the hold limit, last_gnt is excluded from the scan. It is granted only if it is the sole requester, which falls under the sticky case.
- Update on clock edge when !stall:
  - last_vld <= eval.
  - last_gnt <= egnt when eval.
  - ptr <= (egnt+1) mod NR when eval.
  - hold_cnt <= 1 on a grant to a new line, or on any grant following an idle cycle (last_vld=0).
  - hold_cnt <= hold_cnt+1, saturating at MAX_HOLD, on a sticky grant.
- With stall=1, all state holds. A stalled cycle neither breaks stickiness nor counts toward the hold limit.
- Idle cycle (!stall, req=0): last_vld <= 0, ptr unchanged. The next grant goes through round-robin from ptr.

## Timing
- Latency req→grant: 0 cycles (combinational). State effect visible next cycle.
- Wrap-around: ptr from NR-1 goes to 0. For non-power-of-two NR, ptr never holds a value ≥ NR.
- Sole requester with limit reached: keeps the grant indefinitely; hold_cnt stays saturated.
- Sticky line drops req for one cycle while others request: it loses stickiness. It is re-granted only via rotation.
- Simultaneous stall and req change: stall dominates; eval=0 and no state change.
- Reset asserted mid-burst: outputs go to 0 immediately. After release, the first grant is round-robin from line 0.

## Structure
- Shared package/header: clog2 function and the arbiter grant-width helper, reused by other arbiters in the design.
- One combinational sub-module, rr_pick (NR, req, ptr, mask → found, idx). It handles the wrap-around priority scan; the top level holds the state and the sticky/limit logic.
- Target ~150–250 lines total.

## Test plan
- NR=4, MAX_HOLD=3; reset, then req=4'b0110 held: egnt sequence 1,1,1,2,2,2,1,… and eval=1 every cycle.
- MAX_HOLD=3, req=4'b0100 held 10 cycles: egnt=2 every cycle, hold_cnt saturates at 3, no gap.
- Stall sequence:
  - req=4'b0011, grant 0 twice, then stall=1 for 5 cycles: eval=0, vgnt=0.
  - After stall drops: egnt=0 once more (third hold), then egnt=1.
- req=4'b1000 granted, then req=4'b1001: egnt=3 until the limit, then wraps to 0. ptr after the 0-grant is 1.
- Assert reset asynchronously mid-grant (between edges): eval/vgnt/egnt go to 0 in the same cycle. After release with req=4'b1111, the first egnt=0.
- NR=5, MAX_HOLD=0, req toggling 5'b10001 → 5'b10000 → 5'b00001: egnt 0,4,… with unlimited stickiness; ptr wraps from 4 to 0.

Source files
------------

// File: rtl/sticky_rr_arbiter_pkg.sv
// Shared sizing helpers for the arbiter family: log2 and the width of an
// encoded grant / saturating counter.
package sticky_rr_arbiter_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Encoded grant width, never narrower than one bit.
    function automatic int gnt_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    // Width of a counter that must reach max_val.
    function automatic int hold_width(input int max_val);
        return gnt_width(max_val + 1);
    endfunction

endpackage

// File: rtl/sticky_rr_arbiter_rr_pick.sv
// Wrap-around priority scan: first line set in req & mask, starting at ptr and
// rotating through ptr+1, ... modulo NR.
module rr_pick
    import sticky_rr_arbiter_pkg::*;
#(
    parameter int  NR = 4,
    localparam int EW = gnt_width(NR)
) (
    input  logic [NR-1:0] req,
    input  logic [EW-1:0] ptr,
    input  logic [NR-1:0] mask,
    output logic          found,
    output logic [EW-1:0] idx
);

    localparam logic [EW:0] NR_W = (EW+1)'(NR);

    logic [NR-1:0]   elig;
    logic [NR-1:0]   win;
    logic [2*NR-1:0] dbl;
    logic [EW:0]     pos;

    // Doubling the vector turns the wrap-around scan into a plain right shift.
    assign elig = req & mask;
    assign dbl  = {elig, elig};
    assign win  = NR'(dbl >> ptr);

    always_comb begin
        found = 1'b0;
        pos   = '0;
        for (int i = NR - 1; i >= 0; i--) begin
            if (win[i]) begin
                found = 1'b1;
                pos   = {1'b0, ptr} + (EW+1)'(i);
            end
        end
        if (pos >= NR_W) pos = pos - NR_W;
        idx = pos[EW-1:0];
    end

endmodule

// File: rtl/sticky_rr_arbiter.sv
// NR-way round-robin arbiter with sticky grants: the current owner keeps the
// grant while requesting, up to MAX_HOLD grants when others are waiting.
module sticky_rr_arbiter
    import sticky_rr_arbiter_pkg::*;
#(
    parameter int  NR       = 4,
    parameter int  MAX_HOLD = 4,
    localparam int EW       = gnt_width(NR)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [NR-1:0] req,
    input  logic          stall,
    output logic [NR-1:0] vgnt,
    output logic [EW-1:0] egnt,
    output logic          eval
);

    localparam int            HW         = hold_width(MAX_HOLD);
    localparam logic [HW-1:0] MAX_HOLD_W = HW'(MAX_HOLD);
    localparam logic [EW-1:0] LAST_IDX   = EW'(NR - 1);

    logic [EW-1:0] last_gnt_q, last_gnt_d;
    logic          last_vld_q, last_vld_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [EW-1:0] ptr_q,      ptr_d;

    logic [NR-1:0] last_oh;
    logic [NR-1:0] scan_mask;
    logic          others;
    logic          limit_hit;
    logic          sticky;
    logic          pick_found;
    logic [EW-1:0] pick_idx;
    logic [EW-1:0] sel;

    always_comb begin
        last_oh = NR'(1) << last_gnt_q;
        others  = |(req & ~last_oh);
        if (MAX_HOLD == 0) limit_hit = 1'b0;
        else               limit_hit = (hold_cnt_q == MAX_HOLD_W);
        sticky  = last_vld_q && |(req & last_oh) && (!limit_hit || !others);
        // An owner at its limit is skipped; as sole requester it stays sticky.
        scan_mask = (last_vld_q && limit_hit) ? ~last_oh : '1;
    end

    rr_pick #(.NR(NR)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .mask  (scan_mask),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        sel  = sticky ? last_gnt_q : pick_idx;
        eval = !reset && !stall && (sticky || pick_found);
        egnt = eval ? sel : '0;
        vgnt = eval ? (NR'(1) << sel) : '0;
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        last_vld_d = last_vld_q;
        hold_cnt_d = hold_cnt_q;
        ptr_d      = ptr_q;
        if (!stall) begin
            last_vld_d = eval;
            if (eval) begin
                last_gnt_d = sel;
                ptr_d      = (sel == LAST_IDX) ? '0 : sel + EW'(1);
                if (!last_vld_q || sel != last_gnt_q)
                    hold_cnt_d = HW'(1);
                else if (MAX_HOLD != 0 && hold_cnt_q != MAX_HOLD_W)
                    hold_cnt_d = hold_cnt_q + HW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_gnt_q <= '0;
            last_vld_q <= 1'b0;
            hold_cnt_q <= '0;
            ptr_q      <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            last_vld_q <= last_vld_d;
            hold_cnt_q <= hold_cnt_d;
            ptr_q      <= ptr_d;
        end
    end

endmodule
